fetch_queue: RTL and testbench

Parametrised instruction queue between the fetch unit and decode; the successor to the single-entry-per-cycle instruction buffer. Accepts up to FETCH_WIDTH instructions per cycle as a fetch packet tagged with a base PC, and delivers one instruction plus its PC per cycle to decode over a valid/ready handshake. Provides a synchronous flush for branch redirects and occupancy status for fetch throttling.

---
 rtl/fetch_pkg.sv | 5 +
 rtl/fetch_queue_mem.sv | 35 +++
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Constants shared by the fetch queue and its storage; entry types live in
// the modules because they depend on module parameters.
package fetch_pkg;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry instruction/PC storage with FETCH_WIDTH write ports and one
// asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem #(
  parameter int INST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                                     clk,
  input  logic [FETCH_WIDTH-1:0]                   wr_en,
  input  logic [FETCH_WIDTH*$clog2(DEPTH)-1:0]     wr_idx,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0]        wr_inst,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]        wr_pc,
  input  logic [$clog2(DEPTH)-1:0]                 rd_idx,
  output logic [INST_WIDTH-1:0]                    rd_inst,
  output logic [ADDR_WIDTH-1:0]                    rd_pc
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

  // Slot indices within one packet never collide, so port order is irrelevant.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en[k]) begin
        mem_inst[wr_idx[k*IDX_W +: IDX_W]] <= wr_inst[k*INST_WIDTH +: INST_WIDTH];
        mem_pc[wr_idx[k*IDX_W +: IDX_W]]   <= wr_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rd_inst = mem_inst[rd_idx];
  assign rd_pc   = mem_pc[rd_idx];
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: multi-slot packet writes, one-per-cycle
// first-word-fall-through reads, synchronous flush and occupancy status.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int INST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int AF_LEVEL    = DEPTH - FETCH_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic                                in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]    in_count,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0]   in_insts,
  input  logic [ADDR_WIDTH-1:0]               in_pc,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [INST_WIDTH-1:0]               out_inst,
  output logic [ADDR_WIDTH-1:0]               out_pc,
  input  logic                                out_ready,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                almost_full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(FETCH_WIDTH + 1);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high and flush is low; ready never depends on same-cycle valid.
  logic [PTR_W-1:0]                 wptr, rptr, n_wr, free_cnt;
  logic                             wr_fire, rd_fire;
  logic [FETCH_WIDTH-1:0]           wr_en;
  logic [FETCH_WIDTH*IDX_W-1:0]     wr_idx;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] wr_pc;
  logic [INST_WIDTH-1:0]            rd_inst;
  logic [ADDR_WIDTH-1:0]            rd_pc;
  entry_t                           head;

  assign count       = wptr - rptr;
  assign free_cnt    = PTR_W'(DEPTH) - count;
  assign in_ready    = free_cnt >= PTR_W'(FETCH_WIDTH);
  assign out_valid   = count != '0;
  assign almost_full = count >= PTR_W'(AF_LEVEL);
  assign wr_fire     = in_valid & in_ready & ~flush;
  assign rd_fire     = out_valid & out_ready & ~flush;

  // Oversized in_count values are clamped to the packet width.
  always_comb begin
    if (in_count > CNT_W'(FETCH_WIDTH)) n_wr = PTR_W'(FETCH_WIDTH);
    else                                n_wr = PTR_W'(in_count);
  end

  always_comb begin
    wr_en  = '0;
    wr_idx = '0;
    wr_pc  = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_en[k]                          = wr_fire && (PTR_W'(k) < n_wr);
      wr_idx[k*IDX_W +: IDX_W]          = wptr[IDX_W-1:0] + IDX_W'(k);
      wr_pc[k*ADDR_WIDTH +: ADDR_WIDTH] = in_pc + ADDR_WIDTH'(k * INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_fire) wptr <= wptr + n_wr;
      if (rd_fire) rptr <= rptr + 1'b1;
    end
  end

  fetch_queue_mem #(
    .INST_WIDTH (INST_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_inst(in_insts),
    .wr_pc  (wr_pc),
    .rd_idx (rptr[IDX_W-1:0]),
    .rd_inst(rd_inst),
    .rd_pc  (rd_pc)
  );

  assign head     = '{inst: rd_inst, pc: rd_pc};
  assign out_inst = out_valid ? head.inst : '0;
  assign out_pc   = out_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic compared
// against a queue-based model of the instruction stream.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int AF    = DEPTH - FW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_count = '0;
  logic [63:0] in_insts = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        almost_full;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: each entry is {inst, pc}; head at index 0.
  logic [63:0] exp_q[$];

  fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_count(in_count), .in_insts(in_insts), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_ready(out_ready), .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [63:0] hd;
    sz = exp_q.size();
    hd = (sz > 0) ? exp_q[0] : 64'd0;
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz > 0));
    check("out_inst", 64'(out_inst), 64'(hd[63:32]));
    check("out_pc", 64'(out_pc), 64'(hd[31:0]));
    check("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= FW));
    check("almost_full", 64'(almost_full), 64'(sz >= AF));
  endtask

  // Applies the queue rules to the inputs present at the edge just taken.
  task automatic model_edge();
    int sz, n;
    logic [31:0] p;
    sz = exp_q.size();
    if (flush) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && (DEPTH - sz) >= FW) begin
        n = (int'(in_count) > FW) ? FW : int'(in_count);
        for (int k = 0; k < n; k++) begin
          p = in_pc + 32'(4 * k);
          exp_q.push_back({in_insts[k*32 +: 32], p});
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_count  = c;
    in_insts  = {i1, i0};
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_inst"}, 64'(out_inst), 64'd0);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_almost_full"}, 64'(almost_full), 64'd0);
  endtask

  // Called just after an edge with inputs already driven.
  task automatic async_reset_midstream();
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles, input int pv, input int pr);
    logic [31:0] pc;
    for (int i = 0; i < cycles; i++) begin
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      drive($urandom_range(0, 99) < pv, 2'($urandom_range(0, 3)), $urandom(), $urandom(),
            pc, $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 4);
      cycle();
    end
  endtask

  initial begin
    #2 check_reset_values("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle();
    cycle();

    // Basic two-slot packet then drain.
    drive(1'b1, 2'd2, 32'hA, 32'hB, 32'h100, 1'b0, 1'b0);
    cycle();
    idle();
    cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Fill with four packets, then a dropped fifth.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd2, 32'h10 + 32'(2*i), 32'h11 + 32'(2*i), 32'h200 + 32'(8*i), 1'b0, 1'b0);
      cycle();
    end
    idle();
    cycle();

    // Drain to 3, then simultaneous write+read, then up to 6 and write+read to 7.
    out_ready = 1'b1;
    repeat (5) cycle();
    drive(1'b1, 2'd2, 32'h31, 32'h32, 32'h300, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 2'd2, 32'h33, 32'h34, 32'h308, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd2, 32'h35, 32'h36, 32'h310, 1'b1, 1'b0);
    cycle();
    idle();
    cycle();

    // Packets of 1 then 2 slots wrapping the index with continuous reads.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 32'h400 + 32'(i), 32'h500 + 32'(i),
            32'h1000 + 32'(16*i), 1'b1, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (8) cycle();

    // Build count 5, flush with write and read requested, then new packet.
    drive(1'b1, 2'd2, 32'h61, 32'h62, 32'h600, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd2, 32'h63, 32'h64, 32'h608, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd1, 32'h65, 32'h66, 32'h610, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd2, 32'h67, 32'h68, 32'h618, 1'b1, 1'b1); cycle();
    drive(1'b1, 2'd2, 32'h71, 32'h72, 32'h700, 1'b0, 1'b0); cycle();
    idle();
    cycle();

    // Async reset in the middle of traffic, then a fresh write.
    drive(1'b1, 2'd2, 32'h81, 32'h82, 32'h800, 1'b1, 1'b0);
    cycle();
    async_reset_midstream();
    idle();
    cycle();
    drive(1'b1, 2'd2, 32'h91, 32'h92, 32'h900, 1'b0, 1'b0);
    cycle();
    idle();
    cycle();

    // Random traffic: balanced, fill-biased, drain-biased.
    random_phase(300, 60, 60);
    random_phase(200, 80, 20);
    random_phase(200, 20, 80);
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
